// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: FSM state encoding and
// radix-4 Booth digit codes used by the sequential multiplier.
package calc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] BOOTH_ZERO = 3'd0;
   localparam logic [2:0] BOOTH_P1   = 3'd1;
   localparam logic [2:0] BOOTH_P2   = 3'd2;
   localparam logic [2:0] BOOTH_M2   = 3'd3;
   localparam logic [2:0] BOOTH_M1   = 3'd4;

   // Map a multiplier window {b[2i+1], b[2i], b[2i-1]} to its Booth digit
   function automatic logic [2:0] booth_decode(input logic [2:0] win);
      logic [2:0] code;
      case (win)
         3'b001, 3'b010: code = BOOTH_P1;
         3'b011:         code = BOOTH_P2;
         3'b100:         code = BOOTH_M2;
         3'b101, 3'b110: code = BOOTH_M1;
         default:        code = BOOTH_ZERO;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial product generator: one 3-bit multiplier window and
// the extended multiplicand give a WIDTH+4 bit two's complement partial product.
module booth_r4_pp_gen
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       win,
   input  logic [WIDTH+1:0] a_ext,
   output logic [WIDTH+3:0] pp
);

   logic signed [WIDTH+3:0] a_w;
   logic [2:0]              code;

   assign a_w  = signed'({{2{a_ext[WIDTH+1]}}, a_ext});
   assign code = booth_decode(win);

   // Select 0, +-A or +-2A; two guard bits keep -2A of the most negative A exact
   always_comb begin
      pp = '0;
      case (code)
         BOOTH_P1: pp = a_w;
         BOOTH_P2: pp = a_w <<< 1;
         BOOTH_M2: pp = -(a_w <<< 1);
         BOOTH_M1: pp = -a_w;
         default:  pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier. One Booth digit per clock is added into
// the upper half of a shift register that initially holds the multiplier; after
// WIDTH/2+1 digits the register holds the full product.
module booth_r4_seq_mult
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int EW    = WIDTH + 2;   // extended operand width
   localparam int HW    = WIDTH + 4;   // accumulator upper half / partial product width
   localparam int NDIG  = EW / 2;      // Booth digits per operation
   localparam int CNT_W = $clog2(NDIG);

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              last;
   logic [EW-1:0]     a_reg;
   logic [HW-1:0]     hi;
   logic [EW-1:0]     lo;
   logic              bprev;
   logic [HW-1:0]     pp;
   logic [HW-1:0]     hi_sum;
   logic signed [HW+EW-1:0] acc_sum, acc_nxt;
   logic [EW-1:0]     a_ext, b_ext;

   // Zero- or sign-extend both operands so unsigned values use the same signed datapath
   assign a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
   assign b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

   assign last = (cnt == CNT_W'(NDIG - 1));

   booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp (
      .win   ({lo[1:0], bprev}),
      .a_ext (a_reg),
      .pp    (pp)
   );

   assign hi_sum  = hi + pp;
   assign acc_sum = signed'({hi_sum, lo});
   assign acc_nxt = acc_sum >>> 2;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state: accept in IDLE, run NDIG digits, single DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (last)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         ST_IDLE: ready = 1'b1;
         ST_RUN:  busy  = 1'b1;
         ST_DONE: done  = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Datapath: latch operands on accept, shift-add one digit per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         hi      <= '0;
         lo      <= '0;
         bprev   <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_reg <= a_ext;
                  lo    <= b_ext;
                  hi    <= '0;
                  bprev <= 1'b0;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               {hi, lo} <= acc_nxt;
               bprev    <= lo[1];
               cnt      <= cnt + 1'b1;
               if (last) product <= acc_nxt[2*WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: directed corner cases plus randomized
// back-to-back operations on WIDTH=8 and WIDTH=16 instances.
module tb_booth_r4_seq_mult;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_s;
   logic        use16;
   logic [15:0] a_in, b_in;

   logic        start8, ready8, busy8, done8;
   logic [15:0] prod8;
   logic        start16, ready16, busy16, done16;
   logic [31:0] prod16;

   logic        ready_o, busy_o, done_o;
   logic [63:0] prod_o;

   int n_chk  = 0;
   int n_fail = 0;
   int done8_cnt  = 0;
   int done16_cnt = 0;
   int rb_viol    = 0;

   assign start8  = start & ~use16;
   assign start16 = start & use16;
   assign ready_o = use16 ? ready16 : ready8;
   assign busy_o  = use16 ? busy16  : busy8;
   assign done_o  = use16 ? done16  : done8;
   assign prod_o  = use16 ? {32'd0, prod16} : {48'd0, prod8};

   booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .is_signed (is_s),
      .a         (a_in[7:0]),
      .b         (b_in[7:0]),
      .ready     (ready8),
      .busy      (busy8),
      .done      (done8),
      .product   (prod8)
   );

   booth_r4_seq_mult #(.WIDTH(16)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (start16),
      .is_signed (is_s),
      .a         (a_in),
      .b         (b_in),
      .ready     (ready16),
      .busy      (busy16),
      .done      (done16),
      .product   (prod16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses and any cycle where ready and busy are both high
   always @(posedge clk) begin
      if (done8)  done8_cnt  <= done8_cnt + 1;
      if (done16) done16_cnt <= done16_cnt + 1;
      if ((ready8 && busy8) || (ready16 && busy16)) rb_viol <= rb_viol + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer multiply under the chosen interpretation, low 2w bits
   function automatic logic [63:0] ref_mul(input int w, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
      longint x, y, m;
      x = longint'(a);
      y = longint'(b);
      if (sgn && a[w-1]) x = x - (longint'(1) << w);
      if (sgn && b[w-1]) y = y - (longint'(1) << w);
      m = (longint'(1) << (2 * w)) - 1;
      return 64'(x * y & m);
   endfunction

   function automatic int cur_done_cnt();
      return use16 ? done16_cnt : done8_cnt;
   endfunction

   // Issue one op from IDLE (called #1 after an edge); returns at #1 after the
   // edge that leaves DONE, with product and observed latency
   task automatic do_op(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                        output logic [63:0] prod, output int lat);
      int d0;
      d0    = cur_done_cnt();
      is_s  = sgn;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done_o && lat < 40) begin
         if (busy_o !== 1'b1 || ready_o !== 1'b0) chk("run_handshake", {busy_o, ready_o}, 2'b10);
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 40) chk("done_timeout", 64'(lat), 64'(use16 ? 9 : 5));
      prod = prod_o;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) chk("done_handshake", {busy_o, ready_o}, 2'b00);
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || done_o !== 1'b0) chk("back_to_idle", {ready_o, done_o}, 2'b10);
      if (cur_done_cnt() - d0 != 1) chk("done_pulses", 64'(cur_done_cnt() - d0), 64'd1);
   endtask

   logic [63:0] p;
   int          lat, k, d0;

   initial begin
      rst = 1'b1; start = 1'b0; is_s = 1'b0; use16 = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready8, 1'b1);
      chk("rst_busy",  busy8,  1'b0);
      chk("rst_done",  done8,  1'b0);
      chk("rst_prod",  prod8,  16'h0);
      chk("rst_ready16", ready16, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed WIDTH=8 cases
      do_op(1, 16'h07, 16'h03, p, lat);
      chk("s7x3", p, 64'h0015);     chk("s7x3_lat", 64'(lat), 64'd5);
      do_op(1, 16'h80, 16'h80, p, lat);
      chk("s80x80", p, 64'h4000);   chk("s80x80_lat", 64'(lat), 64'd5);
      do_op(1, 16'hFF, 16'h01, p, lat);
      chk("sFFx01", p, 64'hFFFF);
      do_op(0, 16'hFF, 16'hFF, p, lat);
      chk("uFFxFF", p, 64'hFE01);   chk("uFFxFF_lat", 64'(lat), 64'd5);
      do_op(0, 16'h80, 16'h02, p, lat);
      chk("u80x02", p, 64'h0100);

      // start pulsed during RUN and held through DONE must be ignored
      d0 = done8_cnt;
      is_s = 1'b1; a_in = 16'h07; b_in = 16'h03; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a_in = 16'h55; b_in = 16'h33; is_s = 1'b0; start = 1'b1;
      k = 1;
      while (!done8 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("ign_lat",  64'(k), 64'd5);
      chk("ign_prod", prod8, 16'h0015);
      @(posedge clk); #1;
      start = 1'b0;
      chk("ign_done_ready", {ready8, busy8}, 2'b10);
      chk("ign_prod_hold",  prod8, 16'h0015);
      chk("ign_one_done",   64'(done8_cnt - d0), 64'd1);

      // Reset on the third RUN cycle abandons the operation
      d0 = done8_cnt;
      is_s = 1'b1; a_in = 16'h12; b_in = 16'h34; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_ready", {ready8, busy8, done8}, 3'b100);
      chk("mid_rst_prod",  prod8, 16'h0);
      repeat (8) begin @(posedge clk); #1; end
      chk("mid_rst_nodone", 64'(done8_cnt - d0), 64'd0);
      chk("mid_rst_prod_hold", prod8, 16'h0);
      do_op(0, 16'hAB, 16'hCD, p, lat);
      chk("after_rst_op", p, ref_mul(8, 0, 32'hAB, 32'hCD));

      // WIDTH=16 directed case
      use16 = 1'b1;
      do_op(1, 16'h8000, 16'h7FFF, p, lat);
      chk("w16_s8000x7FFF", p, 64'hC0008000);
      chk("w16_lat", 64'(lat), 64'd9);

      // Randomized back-to-back operations, both modes
      use16 = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] ra, rb;
         bit          rs;
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         do_op(rs, ra, rb, p, lat);
         chk("rnd8", p, ref_mul(8, rs, 32'(ra), 32'(rb)));
         chk("rnd8_lat", 64'(lat), 64'd5);
      end
      use16 = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [15:0] ra, rb;
         bit          rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         do_op(rs, ra, rb, p, lat);
         chk("rnd16", p, ref_mul(16, rs, 32'(ra), 32'(rb)));
         chk("rnd16_lat", 64'(lat), 64'd9);
      end

      chk("ready_busy_overlap", 64'(rb_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
